// File: rtl/audio_decoder_if.sv
// I2S receiver bundle: serial bit clock/word select/data in, decoded stereo pair and status out.
interface audio_decoder_if #(
  parameter int SAMPLE_BIT_WIDTH = 16
);
  logic                        audio_bck;
  logic                        audio_ws;
  logic                        audio_data;
  logic [SAMPLE_BIT_WIDTH-1:0] sample_left;
  logic [SAMPLE_BIT_WIDTH-1:0] sample_right;
  logic                        sample_valid;
  logic                        frame_error;
  logic                        locked;

  modport master (
    output audio_bck, audio_ws, audio_data,
    input  sample_left, sample_right, sample_valid, frame_error, locked
  );

  modport slave (
    input  audio_bck, audio_ws, audio_data,
    output sample_left, sample_right, sample_valid, frame_error, locked
  );
endinterface

// File: rtl/audio_decoder.sv
// I2S receiver: synchronises bck/ws/data into clk, frames words on ws changes and
// presents complete left/right pairs; drops lock when bck stalls.
module audio_decoder #(
  parameter int SAMPLE_BIT_WIDTH = 16,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic           clk,
  input  logic           reset,
  audio_decoder_if.slave i2s
);
  localparam int CNT_W = $clog2(SAMPLE_BIT_WIDTH + 2);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SAMPLE_BIT_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SAMPLE_BIT_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_BIT_WIDTH - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

  typedef enum logic {UNSYNC = 1'b0, RECEIVE = 1'b1} state_t;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
  endfunction

  function automatic logic [TMO_W-1:0] sat_inc_tmo(input logic [TMO_W-1:0] v);
    return (v >= TMO_MAX) ? TMO_MAX : v + TMO_W'(1);
  endfunction

  logic bck_p0, bck_p1, bck_p2;
  logic ws_p0, ws_p1;
  logic data_p0, data_p1;
  logic bck_rise;

  state_t state, state_next;
  logic                        prev_ws;
  logic                        ws_seen;
  logic                        word_end;
  logic                        word_full;
  logic [CNT_W-1:0]            bit_cnt;
  logic [TMO_W-1:0]            tmo_cnt;
  logic [SAMPLE_BIT_WIDTH-1:0] shift_reg;
  logic [SAMPLE_BIT_WIDTH-1:0] word_val;
  logic [SAMPLE_BIT_WIDTH-1:0] left_stage;
  logic                        left_vld;
  logic [SAMPLE_BIT_WIDTH-1:0] out_left;
  logic [SAMPLE_BIT_WIDTH-1:0] out_right;
  logic                        out_valid;
  logic                        out_error;
  logic                        locked_r;

  // Stage p0/p1: two-flop synchronisers; bck gets a third flop (p2) for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      bck_p0  <= 1'b0;
      bck_p1  <= 1'b0;
      bck_p2  <= 1'b0;
      ws_p0   <= 1'b0;
      ws_p1   <= 1'b0;
      data_p0 <= 1'b0;
      data_p1 <= 1'b0;
    end else begin
      bck_p0  <= i2s.audio_bck;
      bck_p1  <= bck_p0;
      bck_p2  <= bck_p1;
      ws_p0   <= i2s.audio_ws;
      ws_p1   <= ws_p0;
      data_p0 <= i2s.audio_data;
      data_p1 <= data_p0;
    end
  end

  assign bck_rise  = bck_p1 & ~bck_p2;
  assign word_full = (bit_cnt >= CNT_LAST);
  // The bit arriving with the ws change is the LSB, kept only if the word is not already full
  assign word_val  = (bit_cnt < CNT_FULL) ? {shift_reg[SAMPLE_BIT_WIDTH-2:0], data_p1} : shift_reg;

  always_ff @(posedge clk) begin
    if (reset) state <= UNSYNC;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    word_end   = 1'b0;
    if (bck_rise) begin
      if (state == UNSYNC) begin
        if (ws_seen && (ws_p1 != prev_ws)) state_next = RECEIVE;
      end else begin
        word_end = (ws_p1 != prev_ws);
      end
    end else if ((state == RECEIVE) && (tmo_cnt == TMO_MAX)) begin
      state_next = UNSYNC;
    end
  end

  // Stage p2: framing control, pair staging and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_ws   <= 1'b0;
      ws_seen   <= 1'b0;
      bit_cnt   <= '0;
      tmo_cnt   <= '0;
      left_vld  <= 1'b0;
      out_left  <= '0;
      out_right <= '0;
      out_valid <= 1'b0;
      out_error <= 1'b0;
      locked_r  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_error <= 1'b0;
      locked_r  <= (state_next == RECEIVE);
      if (bck_rise) begin
        prev_ws <= ws_p1;
        ws_seen <= 1'b1;
        tmo_cnt <= '0;
        if ((state == UNSYNC) || word_end) begin
          bit_cnt <= '0;
        end else begin
          bit_cnt <= sat_inc_cnt(bit_cnt);
        end
        if (word_end) begin
          if (!word_full) begin
            out_error <= 1'b1;
            left_vld  <= 1'b0;
          end else if (!prev_ws) begin
            left_vld <= 1'b1;
          end else if (left_vld) begin
            out_left  <= left_stage;
            out_right <= word_val;
            out_valid <= 1'b1;
            left_vld  <= 1'b0;
          end
        end
      end else begin
        tmo_cnt <= sat_inc_tmo(tmo_cnt);
        if ((state == RECEIVE) && (state_next == UNSYNC)) left_vld <= 1'b0;
      end
    end
  end

  // Data-only registers: contents are qualified by bit_cnt/left_vld, so they need no reset
  always_ff @(posedge clk) begin
    if (bck_rise) begin
      if ((state == UNSYNC) || word_end) begin
        shift_reg <= '0;
      end else if (bit_cnt < CNT_FULL) begin
        shift_reg <= {shift_reg[SAMPLE_BIT_WIDTH-2:0], data_p1};
      end
      if (word_end && word_full && !prev_ws) left_stage <= word_val;
    end
  end

  assign i2s.sample_left  = out_left;
  assign i2s.sample_right = out_right;
  assign i2s.sample_valid = out_valid;
  assign i2s.frame_error  = out_error;
  assign i2s.locked       = locked_r;
endmodule

// File: tb/tb_audio_decoder.sv
// Bench for audio_decoder: frame table, hand-built corner sequences and a random stream
// checked against a word-level I2S reference model.
module tb_audio_decoder;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  audio_decoder_if #(.SAMPLE_BIT_WIDTH(W)) bus ();

  audio_decoder #(.SAMPLE_BIT_WIDTH(W), .TIMEOUT_CYCLES(1024)) dut (
    .clk   (clk),
    .reset (reset),
    .i2s   (bus)
  );

  int checks   = 0;
  int failures = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  // Reference model: sees the bit stream one bck rise at a time and works in whole words
  typedef struct { logic [W-1:0] l; logic [W-1:0] r; } pair_t;
  pair_t        exp_q[$];
  bit           m_bits[$];
  bit           m_seen, m_lock, m_prev, m_stv;
  logic [W-1:0] m_stage;
  int           m_err   = 0;
  int           m_valid = 0;

  function automatic void model_reset();
    m_seen = 0; m_lock = 0; m_prev = 0; m_stv = 0;
    m_bits.delete();
    exp_q.delete();
  endfunction

  function automatic void model_timeout();
    m_lock = 0; m_stv = 0;
    m_bits.delete();
  endfunction

  function automatic void model_rise(bit ws, bit d);
    logic [W-1:0] v;
    pair_t        p;
    if (!m_seen) begin
      m_seen = 1; m_prev = ws;
      return;
    end
    if (!m_lock) begin
      if (ws != m_prev) begin
        m_lock = 1;
        m_bits.delete();
      end
      m_prev = ws;
      return;
    end
    m_bits.push_back(d);
    if (ws != m_prev) begin
      if (m_bits.size() >= W) begin
        v = '0;
        for (int i = 0; i < W; i++) v = {v[W-2:0], m_bits[i]};
        if (m_prev == 1'b0) begin
          m_stage = v; m_stv = 1;
        end else if (m_stv) begin
          p.l = m_stage; p.r = v;
          exp_q.push_back(p);
          m_valid++;
          m_stv = 0;
        end
      end else begin
        m_err++;
        m_stv = 0;
      end
      m_bits.delete();
    end
    m_prev = ws;
  endfunction

  // Output monitor, sampled on the falling clk edge
  int n_valid = 0;
  int n_err   = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.sample_valid) begin
        pair_t p;
        n_valid++;
        chk("pair_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          p = exp_q.pop_front();
          chk("pair_left", 32'(bus.sample_left), 32'(p.l));
          chk("pair_right", 32'(bus.sample_right), 32'(p.r));
        end
      end
      if (bus.frame_error) n_err++;
      if (bus.sample_valid || bus.frame_error) chk("pulse_only_when_locked", 32'(bus.locked), 32'd1);
    end
  end

  task automatic bck_cycle(input logic ws, input logic d, input int half);
    bus.audio_bck  = 1'b0;
    bus.audio_ws   = ws;
    bus.audio_data = d;
    repeat (half) @(negedge clk);
    bus.audio_bck = 1'b1;
    model_rise(ws, d);
    repeat (half) @(negedge clk);
  endtask

  // Assumes the left slot's first rise (carrying the previous LSB) already happened
  task automatic send_frame(input logic [31:0] l, input int lb, input logic [31:0] r, input int rb, input int half);
    for (int i = lb - 1; i >= 1; i--) bck_cycle(1'b0, l[i], half);
    bck_cycle(1'b1, l[0], half);
    for (int i = rb - 1; i >= 1; i--) bck_cycle(1'b1, r[i], half);
    bck_cycle(1'b0, r[0], half);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_left"},   32'(bus.sample_left),  32'd0);
    chk({tag, "_right"},  32'(bus.sample_right), 32'd0);
    chk({tag, "_valid"},  32'(bus.sample_valid), 32'd0);
    chk({tag, "_error"},  32'(bus.frame_error),  32'd0);
    chk({tag, "_locked"}, 32'(bus.locked),       32'd0);
  endtask

  typedef struct {
    logic [31:0] l; int lb; logic [31:0] r; int rb;
    int dv; int de; logic [W-1:0] el; logic [W-1:0] er;
  } vec_t;
  vec_t tbl[9];

  initial begin
    int v0, e0, lb, rb;
    logic [31:0] lv, rv;

    tbl[0] = '{32'h1234,   16, 32'hABCD,   16, 1, 0, 16'h1234, 16'hABCD};
    tbl[1] = '{32'h1234,   16, 32'hABCD,   16, 1, 0, 16'h1234, 16'hABCD};
    tbl[2] = '{32'h1234,   16, 32'hABCD,   16, 1, 0, 16'h1234, 16'hABCD};
    tbl[3] = '{32'hA5C37E, 24, 32'h0F00FF, 24, 1, 0, 16'hA5C3, 16'h0F00};
    tbl[4] = '{32'h0ABC,   12, 32'h5555,   16, 0, 1, 16'hA5C3, 16'h0F00};
    tbl[5] = '{32'hFFFF,   16, 32'h0001,   16, 1, 0, 16'hFFFF, 16'h0001};
    tbl[6] = '{32'h10001,  17, 32'h7FFF,   16, 1, 0, 16'h8000, 16'h7FFF};
    tbl[7] = '{32'h1111,   16, 32'h1234,   15, 0, 1, 16'h8000, 16'h7FFF};
    tbl[8] = '{32'h3333,   16, 32'h4444,   16, 1, 0, 16'h3333, 16'h4444};

    model_reset();
    reset = 1'b1;
    bus.audio_bck = 1'b0; bus.audio_ws = 1'b0; bus.audio_data = 1'b0;
    repeat (4) @(posedge clk);
    #1 check_outputs_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Partial right word before the first ws edge: must not lock or output
    bck_cycle(1'b1, 1'b0, 4);
    bck_cycle(1'b1, 1'b1, 4);
    chk("locked_before_ws_edge", 32'(bus.locked), 32'd0);

    // Lock-inducing rise: register update lands on the 3rd clk edge after bck is driven high
    bus.audio_bck = 1'b0; bus.audio_ws = 1'b0; bus.audio_data = 1'b0;
    repeat (4) @(negedge clk);
    bus.audio_bck = 1'b1;
    model_rise(1'b0, 1'b0);
    @(posedge clk); #1 chk("latency_edge1", 32'(bus.locked), 32'd0);
    @(posedge clk); #1 chk("latency_edge2", 32'(bus.locked), 32'd0);
    @(posedge clk); #1 chk("latency_edge3", 32'(bus.locked), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("no_pair_from_partial_word", 32'(n_valid), 32'd0);

    for (int i = 0; i < 9; i++) begin
      v0 = n_valid; e0 = n_err;
      send_frame(tbl[i].l, tbl[i].lb, tbl[i].r, tbl[i].rb, 4);
      repeat (3) @(negedge clk);
      chk($sformatf("vec%0d_valid_pulses", i), 32'(n_valid - v0), 32'(tbl[i].dv));
      chk($sformatf("vec%0d_error_pulses", i), 32'(n_err - e0), 32'(tbl[i].de));
      chk($sformatf("vec%0d_left", i), 32'(bus.sample_left), 32'(tbl[i].el));
      chk($sformatf("vec%0d_right", i), 32'(bus.sample_right), 32'(tbl[i].er));
    end

    // bck stalls mid right word: lock lost after the timeout, outputs hold
    lv = 32'h5A5A;
    for (int i = 15; i >= 1; i--) bck_cycle(1'b0, lv[i], 4);
    bck_cycle(1'b1, lv[0], 4);
    bck_cycle(1'b1, 1'b1, 4);
    bck_cycle(1'b1, 1'b0, 4);
    repeat (900) @(negedge clk);
    chk("timeout_still_locked", 32'(bus.locked), 32'd1);
    repeat (200) @(negedge clk);
    model_timeout();
    chk("timeout_unlocked", 32'(bus.locked), 32'd0);
    chk("timeout_left_hold", 32'(bus.sample_left), 32'h3333);
    chk("timeout_right_hold", 32'(bus.sample_right), 32'h4444);
    bck_cycle(1'b1, 1'b0, 4);
    bck_cycle(1'b1, 1'b0, 4);
    chk("no_relock_without_ws_edge", 32'(bus.locked), 32'd0);
    bck_cycle(1'b0, 1'b0, 4);
    chk("relock_on_ws_edge", 32'(bus.locked), 32'd1);
    v0 = n_valid;
    send_frame(32'h0F0F, 16, 32'hF0F0, 16, 4);
    repeat (3) @(negedge clk);
    chk("relock_pair_count", 32'(n_valid - v0), 32'd1);
    chk("relock_left", 32'(bus.sample_left), 32'h0F0F);
    chk("relock_right", 32'(bus.sample_right), 32'hF0F0);

    // Reset pulse in the middle of a right word
    lv = 32'hC3C3; rv = 32'h3C3C;
    for (int i = 15; i >= 1; i--) bck_cycle(1'b0, lv[i], 4);
    bck_cycle(1'b1, lv[0], 4);
    for (int i = 15; i >= 9; i--) bck_cycle(1'b1, rv[i], 4);
    bus.audio_bck = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1 check_outputs_zero("midword_reset");
    @(negedge clk);
    reset = 1'b0;
    v0 = n_valid; e0 = n_err;
    for (int i = 8; i >= 1; i--) bck_cycle(1'b1, rv[i], 4);
    bck_cycle(1'b0, rv[0], 4);
    repeat (3) @(negedge clk);
    chk("post_reset_no_pair", 32'(n_valid - v0), 32'd0);
    chk("post_reset_no_error", 32'(n_err - e0), 32'd0);
    chk("post_reset_relocked", 32'(bus.locked), 32'd1);
    send_frame(32'h2468, 16, 32'h1357, 16, 4);
    repeat (3) @(negedge clk);
    chk("post_reset_first_pair", 32'(n_valid - v0), 32'd1);
    chk("post_reset_left", 32'(bus.sample_left), 32'h2468);
    chk("post_reset_right", 32'(bus.sample_right), 32'h1357);

    // Random stream with bck at clk/4, occasionally short or long words
    for (int f = 0; f < 32; f++) begin
      lb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 24)) : 16;
      rb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 24)) : 16;
      lv = $urandom;
      rv = $urandom;
      send_frame(lv, lb, rv, rb, 2);
    end
    repeat (10) @(negedge clk);

    chk("pairs_outstanding", 32'(exp_q.size()), 32'd0);
    chk("valid_total", 32'(n_valid), 32'(m_valid));
    chk("frame_error_total", 32'(n_err), 32'(m_err));
    chk("final_locked", 32'(bus.locked), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
